// File: rtl/delay_timer_pkg.sv
// Shared constants for the delay timer: FSM state encodings, reload modes
// and the prescaler width helper.
package delay_timer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COUNT   = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  // ceil(log2(p)) with a floor of one bit, so PRESCALE = 1 still gets a register.
  function automatic int prescale_width(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clock1 down to one tick every PRESCALE enabled cycles; clear restarts
// the division so the first tick lands PRESCALE cycles later.
module tick_prescaler
  import delay_timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock1,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            PW     = prescale_width(PRESCALE);
  localparam logic [PW-1:0] RELOAD = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;

  // The value held while idle is never observed: every start clears it first.
  always_ff @(posedge clock1 or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= RELOAD;
    end else if (enable) begin
      r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - 1'b1;
    end
  end

  assign tick = enable && (r_cnt == '0);

endmodule

// File: rtl/delay_timer.sv
// Programmable down-counting delay timer with one-shot or periodic expiry,
// hold, abort and a shared prescaler.
module delay_timer
  import delay_timer_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int PRESCALE = 1
) (
  input  logic             clock1,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_done;

  logic w_tick;
  logic w_enable;
  logic w_reload;
  logic w_clear;

  assign w_enable = (r_state == ST_COUNT) && !hold;
  assign w_reload = w_tick && (r_count == '0) && (auto_reload == MODE_RELOAD);
  assign w_clear  = start || abort || w_reload;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock1 (clock1),
    .reset_n(reset_n),
    .clear  (w_clear),
    .enable (w_enable),
    .tick   (w_tick)
  );

  // Abort beats start; w_tick already folds in COUNT state and hold.
  always_ff @(posedge clock1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (start) begin
      r_state <= ST_COUNT;
      r_count <= load_value;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_tick) begin
        if (r_count != '0) begin
          r_count <= r_count - 1'b1;
        end else begin
          r_done <= 1'b1;
          if (auto_reload == MODE_ONESHOT) begin
            r_state <= ST_EXPIRED;
          end else begin
            r_count <= load_value;
          end
        end
      end
    end
  end

  assign busy    = (r_state == ST_COUNT);
  assign expired = (r_state == ST_EXPIRED);
  assign done    = r_done;
  assign count   = r_count;

endmodule

// File: doc/delay_timer.md
DELAY_TIMER -- requirements
Module: delay_timer

Interface
REQ-001 Parameter WIDTH, default 12: bit width of load value and down-counter.
REQ-002 Parameter PRESCALE, default 1, legal range 1..65535: clock1 cycles per count tick.
REQ-003 clock1  input  1: single clock, all state changes on rising edge.
REQ-004 reset_n  input  1: reset, asynchronous, active-low.
REQ-005 start  input  1: load load_value and begin counting; sampled each rising edge.
REQ-006 abort  input  1: cancel any count and return to IDLE.
REQ-007 hold  input  1: freeze prescaler and counter while high.
REQ-008 auto_reload  input  1: 0 = one-shot, 1 = periodic; sampled at each expiry.
REQ-009 load_value  input  WIDTH: delay length in ticks; sampled on start and on each auto-reload.
REQ-010 expired  output  1: level, high while in EXPIRED state.
REQ-011 done  output  1: one-cycle pulse on every expiry, one-shot or periodic.
REQ-012 busy  output  1: high while in COUNT state.
REQ-013 count  output  WIDTH: current down-counter value.

Function
REQ-014 States: IDLE, COUNT and EXPIRED, held in one registered state variable.
REQ-015 start in any state: counter <= load_value, prescaler <= PRESCALE-1, state <= COUNT, expired <= 0 on that edge.
REQ-016 abort in any state: state <= IDLE, counter <= 0, prescaler <= 0, expired <= 0, done <= 0.
REQ-017 start and abort on the same edge: abort wins.
REQ-018 In COUNT with hold low, prescaler != 0: prescaler decrements; counter is unchanged.
REQ-019 In COUNT with hold low, prescaler == 0 (tick): prescaler <= PRESCALE-1.
  - Same tick, counter != 0: counter decrements by 1.
  - Same tick, counter == 0: expiry.
REQ-020 On expiry with auto_reload = 0: state <= EXPIRED, expired <= 1, done <= 1 for exactly one cycle.
REQ-021 On expiry with auto_reload = 1: counter <= load_value, state stays COUNT, done <= 1 for one cycle, expired stays 0.
REQ-022 Latency: expiry occurs (N+1)*PRESCALE rising edges after the start edge, where N = sampled load_value; load_value 0 gives expiry after PRESCALE edges.
REQ-023 hold high in COUNT: prescaler, counter and state are frozen; hold has no effect in IDLE or EXPIRED; start and abort override hold.
REQ-024 The counter never wraps: it does not decrement below 0 and has no modular arithmetic.
REQ-025 EXPIRED persists until start or abort; in EXPIRED, count = 0.
REQ-026 start during COUNT restarts the count from the new load_value; no done pulse is generated for the cancelled count.
REQ-027 Outputs are registered; busy and expired are decoded from the registered state with no combinational path from inputs.

Reset
REQ-028 reset_n low asynchronously forces: state = IDLE, counter = 0, prescaler = 0, expired = 0, done = 0, busy = 0, count = 0.
REQ-029 Release of reset_n mid-count leaves the block in IDLE; no count resumes.

Structure
REQ-030 Shared package delay_timer_pkg holds:
  - state enumeration (IDLE, COUNT, EXPIRED);
  - mode constants MODE_ONESHOT = 0 and MODE_RELOAD = 1.
REQ-031 Prescaler is sub-module tick_prescaler (parameter PRESCALE; ports clock1, reset_n, clear, enable, tick).
  - clear is driven by start, abort and reload.
  - enable is driven by COUNT and not hold.
  - PRESCALE = 1 gives tick every enabled cycle.
REQ-032 Prescaler width is ceil(log2(PRESCALE)), minimum 1.

Verification
REQ-033 WIDTH = 12, PRESCALE = 1, load 5, start pulse, one-shot -> busy for 6 cycles; expired rises and done pulses on the 6th edge after start; count sequence 5,4,3,2,1,0.
REQ-034 PRESCALE = 4, load 2, one-shot -> done exactly 12 edges after start; count changes every 4 cycles.
REQ-035 auto_reload = 1, load 3, PRESCALE = 1 -> done pulses every 4 cycles, expired stays 0 throughout; abort stops the pulses, busy drops next edge.
REQ-036 Load 10, hold high for 7 cycles mid-count -> done delayed by exactly 7 cycles versus the no-hold run (11 edges becomes 18).
REQ-037 Start and abort on the same edge -> IDLE, busy 0; start at count 2 with load 9 -> restart, no done until 10 edges later.
REQ-038 reset_n asserted between edges during COUNT -> all outputs 0 immediately, before the next clock1 edge; after release, IDLE until start.
